// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the ALU floating-point units: rounding modes,
// operand classes, divider states and special constants.
`default_nettype none

package fp_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rmode_e;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } div_state_e;

  typedef struct packed {
    logic ovrf;
    logic udrf;
    logic zer;
    logic inf;
    logic nan;
    logic dz;
  } fp_flags_t;

  localparam logic [31:0] FP_CANON_NAN = 32'h7fc0_0000;
  localparam logic [9:0]  FP_BIAS      = 10'd127;
  localparam logic [7:0]  EXP_MAX      = 8'hff;

  // Subnormals collapse into the zero class.
  function automatic fp_class_e fp_classify(input logic [31:0] v);
    fp_class_e c;
    if (v[30:23] == 8'h00)         c = CLS_ZERO;
    else if (v[30:23] != EXP_MAX)  c = CLS_NORM;
    else if (v[22:0] == 23'd0)     c = CLS_INF;
    else                           c = CLS_NAN;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_round_unit.sv
// Combinational FP mantissa rounder: applies the rounding mode to a 24-bit
// mantissa using guard/sticky; carry_o flags a mantissa overflow.
`default_nettype none

module fp_round_unit
  import fp_pkg::*;
(
  input  logic [23:0] mant_i,
  input  logic        guard_i,
  input  logic        sticky_i,
  input  logic        sign_i,
  input  logic [2:0]  r_mode_i,
  output logic [23:0] mant_o,
  output logic        carry_o
);

  logic inc_w;

  always_comb begin
    inc_w = 1'b0;
    case (rmode_e'(r_mode_i))
      RM_RTZ:  inc_w = 1'b0;
      RM_RDN:  inc_w = (guard_i | sticky_i) & sign_i;
      RM_RUP:  inc_w = (guard_i | sticky_i) & ~sign_i;
      RM_RMM:  inc_w = guard_i;
      default: inc_w = guard_i & (sticky_i | mant_i[0]);
    endcase
  end

  assign {carry_o, mant_o} = {1'b0, mant_i} + {24'd0, inc_w};

endmodule

`default_nettype wire

// File: rtl/fp_div_seq.sv
// Iterative binary32 divider (restoring recurrence) with valid/ready handshake.
// Define FP_DIV_RADIX4_EN to retire two quotient bits per DIV cycle.
`default_nettype none

module fp_div_seq
  import fp_pkg::*;
#(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        zer,
  output logic        inf,
  output logic        nan,
  output logic        dz
);

`ifdef FP_DIV_RADIX4_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif
  localparam int          DIV_CYCLES = QBITS / STEPS;
  localparam logic [4:0]  LAST_CNT   = 5'(DIV_CYCLES - 1);

  div_state_e        state_q, state_d;
  logic              sign_q;
  logic [2:0]        rmode_q;
  logic signed [9:0] exp_q;
  logic [24:0]       rem_q, rem_d;
  logic [23:0]       div_q;
  logic [QBITS-1:0]  quo_q, quo_d;
  logic [4:0]        cnt_q;
  logic [31:0]       z_q;
  fp_flags_t         flags_q;

  // Operand classification and special-case result
  fp_class_e  cls_x_w, cls_y_w;
  logic       special_w;
  logic [31:0] spec_z_w;
  fp_flags_t  spec_f_w;
  logic       sign_in_w;

  assign cls_x_w   = fp_classify(fp_X);
  assign cls_y_w   = fp_classify(fp_Y);
  assign sign_in_w = fp_X[31] ^ fp_Y[31];

  always_comb begin
    special_w = 1'b1;
    spec_z_w  = 32'd0;
    spec_f_w  = '0;
    if (cls_x_w == CLS_NAN || cls_y_w == CLS_NAN ||
        (cls_x_w == CLS_INF  && cls_y_w == CLS_INF) ||
        (cls_x_w == CLS_ZERO && cls_y_w == CLS_ZERO)) begin
      spec_z_w     = FP_CANON_NAN;
      spec_f_w.nan = 1'b1;
    end else if (cls_x_w == CLS_INF) begin
      spec_z_w     = {sign_in_w, EXP_MAX, 23'd0};
      spec_f_w.inf = 1'b1;
    end else if (cls_y_w == CLS_ZERO) begin
      spec_z_w     = {sign_in_w, EXP_MAX, 23'd0};
      spec_f_w.inf = 1'b1;
      spec_f_w.dz  = 1'b1;
    end else if (cls_x_w == CLS_ZERO || cls_y_w == CLS_INF) begin
      spec_z_w     = {sign_in_w, 31'd0};
      spec_f_w.zer = 1'b1;
    end else begin
      special_w    = 1'b0;
    end
  end

  // Restoring recurrence; rem stays below 2*div so 25 bits never overflow.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    for (int k = 0; k < STEPS; k++) begin
      if (rem_d >= {1'b0, div_q}) begin
        rem_d = (rem_d - {1'b0, div_q}) << 1;
        quo_d = {quo_d[QBITS-2:0], 1'b1};
      end else begin
        rem_d = rem_d << 1;
        quo_d = {quo_d[QBITS-2:0], 1'b0};
      end
    end
  end

  // Normalise, round and range-check the finished quotient
  logic              norm_w;
  logic [23:0]       mant_pre_w, mant_rnd_w, mant_fin_w;
  logic              guard_w, sticky_w, carry_w;
  logic signed [9:0] exp_adj_w, exp_fin_w;
  logic [31:0]       rnd_z_w;
  fp_flags_t         rnd_f_w;

  assign norm_w = quo_q[QBITS-1];

  always_comb begin
    if (norm_w) begin
      mant_pre_w = quo_q[QBITS-1 -: 24];
      guard_w    = quo_q[QBITS-25];
      sticky_w   = (|quo_q[QBITS-26:0]) | (rem_q != 25'd0);
      exp_adj_w  = exp_q;
    end else begin
      mant_pre_w = quo_q[QBITS-2 -: 24];
      guard_w    = quo_q[QBITS-26];
      sticky_w   = (QBITS > 26) ? (|quo_q[QBITS-26:0] & ~quo_q[QBITS-26]) | (rem_q != 25'd0)
                                : (rem_q != 25'd0);
      exp_adj_w  = exp_q - 10'sd1;
    end
  end

  fp_round_unit u_round (
    .mant_i   (mant_pre_w),
    .guard_i  (guard_w),
    .sticky_i (sticky_w),
    .sign_i   (sign_q),
    .r_mode_i (rmode_q),
    .mant_o   (mant_rnd_w),
    .carry_o  (carry_w)
  );

  assign mant_fin_w = carry_w ? 24'h800000 : mant_rnd_w;
  assign exp_fin_w  = exp_adj_w + (carry_w ? 10'sd1 : 10'sd0);

  always_comb begin
    rnd_f_w = '0;
    if (exp_fin_w >= 10'sd255) begin
      rnd_z_w      = {sign_q, EXP_MAX, 23'd0};
      rnd_f_w.ovrf = 1'b1;
      rnd_f_w.inf  = 1'b1;
    end else if (exp_fin_w <= 10'sd0) begin
      rnd_z_w      = {sign_q, 31'd0};
      rnd_f_w.udrf = 1'b1;
      rnd_f_w.zer  = 1'b1;
    end else begin
      rnd_z_w      = {sign_q, exp_fin_w[7:0], mant_fin_w[22:0]};
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = special_w ? ST_DONE : ST_DIV;
      ST_DIV:   if (cnt_q == LAST_CNT) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q  <= 1'b0;
      rmode_q <= 3'd0;
      exp_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      flags_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q  <= sign_in_w;
            rmode_q <= r_mode;
            cnt_q   <= '0;
            quo_q   <= '0;
            if (special_w) begin
              z_q     <= spec_z_w;
              flags_q <= spec_f_w;
            end else begin
              rem_q <= {2'b01, fp_X[22:0]};
              div_q <= {1'b1, fp_Y[22:0]};
              exp_q <= $signed({2'b00, fp_X[30:23]}) - $signed({2'b00, fp_Y[30:23]})
                       + $signed(FP_BIAS);
            end
          end
        end
        ST_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
        end
        ST_ROUND: begin
          z_q     <= rnd_z_w;
          flags_q <= rnd_f_w;
        end
        default: ;
      endcase
    end
  end

  assign fp_Z = z_q;
  assign ovrf = flags_q.ovrf;
  assign udrf = flags_q.udrf;
  assign zer  = flags_q.zer;
  assign inf  = flags_q.inf;
  assign nan  = flags_q.nan;
  assign dz   = flags_q.dz;

endmodule

`default_nettype wire
